// File: rtl/seven_seg_capture.sv
// Receive side of a multiplexed seven-segment bus: debounces each
// digit slot, decodes segments to hex and assembles full frames.
module seven_seg_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    value_valid,
  output logic                    decode_err,
  output logic [NUM_DIGITS-1:0]   digit_mask
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  state_t                  r_state;
  logic [NUM_DIGITS-1:0]   r_an_q;
  logic [6:0]              r_seg_q;
  logic [CW-1:0]           r_stab_cnt;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [4*NUM_DIGITS-1:0] r_value;
  logic [NUM_DIGITS-1:0]   r_mask;
  logic                    r_valid;
  logic                    r_err;

  logic [NUM_DIGITS-1:0]   w_sel;
  logic                    w_same;
  logic                    w_blank;
  logic                    w_single;
  logic                    w_stable;
  logic                    w_legal;
  logic [3:0]              w_nib;
  logic                    w_done;
  logic [4*NUM_DIGITS-1:0] w_shadow_nxt;

  function automatic logic [4:0] f_decode(input logic [6:0] s);
    case (s)
      7'b1000000: return {1'b1, 4'h0};
      7'b1111001: return {1'b1, 4'h1};
      7'b0100100: return {1'b1, 4'h2};
      7'b0110000: return {1'b1, 4'h3};
      7'b0011001: return {1'b1, 4'h4};
      7'b0010010: return {1'b1, 4'h5};
      7'b0000010: return {1'b1, 4'h6};
      7'b1111000: return {1'b1, 4'h7};
      7'b0000000: return {1'b1, 4'h8};
      7'b0010000: return {1'b1, 4'h9};
      7'b0001000: return {1'b1, 4'hA};
      7'b0000011: return {1'b1, 4'hB};
      7'b1000110: return {1'b1, 4'hC};
      7'b0100001: return {1'b1, 4'hD};
      7'b0000110: return {1'b1, 4'hE};
      7'b0001110: return {1'b1, 4'hF};
      default:    return 5'b0_0000;
    endcase
  endfunction

  assign w_sel    = ~an;
  assign w_same   = ({r_an_q, r_seg_q} == {an, seg});
  assign w_blank  = (w_sel == '0);
  assign w_single = !w_blank
                  && ((w_sel & (w_sel - NUM_DIGITS'(1))) == '0);
  assign w_stable = w_same
                  && (r_stab_cnt == CW'(STABLE_CYCLES - 1));
  assign {w_legal, w_nib} = f_decode(seg);
  assign w_done   = &(r_mask | w_sel);

  // One-hot anode select steers the nibble into its slot
  always_comb begin
    w_shadow_nxt = r_shadow;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_sel[i]) w_shadow_nxt[4*i +: 4] = w_nib;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_an_q     <= '1;
      r_seg_q    <= '1;
      r_stab_cnt <= '0;
      r_shadow   <= '0;
      r_value    <= '0;
      r_mask     <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_an_q  <= an;
      r_seg_q <= seg;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (!w_same)
        r_stab_cnt <= '0;
      else if (r_stab_cnt != CW'(STABLE_CYCLES))
        r_stab_cnt <= r_stab_cnt + CW'(1);
      unique case (r_state)
        IDLE: begin
          if (w_single) r_state <= SETTLE;
        end
        SETTLE: begin
          if (!w_same) begin
            if (w_blank) r_state <= IDLE;
          end else if (w_stable) begin
            r_state <= HOLD;
            if (w_single && w_legal) begin
              r_shadow <= w_shadow_nxt;
              if (w_done) begin
                r_value <= w_shadow_nxt;
                r_valid <= 1'b1;
                r_mask  <= '0;
              end else begin
                r_mask <= r_mask | w_sel;
              end
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (!w_same) r_state <= w_single ? SETTLE : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign value       = r_value;
  assign value_valid = r_valid;
  assign decode_err  = r_err;
  assign digit_mask  = r_mask;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: directed dwell table, corner
// sequences and random dwells against a dwell-level model.
module tb_seven_seg_capture;

  localparam int N = 4;
  localparam int S = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  an  = '1;
  logic [6:0]  seg = '1;
  logic [15:0] value;
  logic        value_valid;
  logic        decode_err;
  logic [3:0]  digit_mask;

  seven_seg_capture #(
    .NUM_DIGITS(N),
    .STABLE_CYCLES(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .an(an),
    .seg(seg),
    .value(value),
    .value_valid(value_valid),
    .decode_err(decode_err),
    .digit_mask(digit_mask)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_valid;
  int n_err;

  logic [6:0] pat [16];

  // dwell-level reference state
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  int          m_run;
  bit          m_armed;
  bit          m_fired;
  logic [3:0]  m_dig [4];
  logic [3:0]  m_got;
  logic [15:0] m_value;
  bit          m_valid;
  bit          m_err;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    int          cyc;
    logic [3:0]  mask;
    logic [15:0] value;
    int          nv;
    int          ne;
  } row_t;

  row_t tbl [16];

  function automatic int decode(input logic [6:0] s);
    for (int k = 0; k < 16; k++) if (pat[k] == s) return k;
    return -1;
  endfunction

  function automatic int zeros(input logic [3:0] a);
    int z = 0;
    for (int k = 0; k < 4; k++) if (!a[k]) z++;
    return z;
  endfunction

  function automatic int zidx(input logic [3:0] a);
    for (int k = 0; k < 4; k++) if (!a[k]) return k;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic [3:0] a, input logic [6:0] s,
                            input logic r);
    int z;
    int d;
    m_valid = 0;
    m_err   = 0;
    if (r) begin
      m_an = '1; m_seg = '1; m_run = 1;
      m_armed = 0; m_fired = 1;
      m_got = '0; m_value = '0;
      for (int k = 0; k < 4; k++) m_dig[k] = '0;
      return;
    end
    z = zeros(a);
    if (a == m_an && s == m_seg) begin
      m_run++;
    end else begin
      if (z == 1) m_armed = 1;
      else if (z == 0) m_armed = 0;
      else m_armed = m_armed && !m_fired;
      m_fired = 0;
      m_run   = 1;
      m_an    = a;
      m_seg   = s;
    end
    if (m_run == S + 1 && m_armed && !m_fired) begin
      m_fired = 1;
      d = decode(s);
      if (z == 1 && d >= 0) begin
        m_dig[zidx(a)] = 4'(d);
        m_got[zidx(a)] = 1'b1;
        if (&m_got) begin
          m_value = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
          m_valid = 1;
          m_got   = '0;
        end
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic cyc(input logic [3:0] a, input logic [6:0] s,
                     input logic r);
    an  = a;
    seg = s;
    rst = r;
    @(posedge clk);
    model_step(a, s, r);
    #1;
    n_valid += int'(value_valid);
    n_err   += int'(decode_err);
    chk("model", {value, value_valid, decode_err, digit_mask},
        {m_value, m_valid, m_err, m_got});
  endtask

  task automatic dwell(input logic [3:0] a, input logic [6:0] s,
                       input int n);
    repeat (n) cyc(a, s, 1'b0);
  endtask

  initial begin
    logic [3:0] ra;
    logic [6:0] rs;
    int         sel;
    pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    tbl[0]  = '{4'b1110, pat[1],     32, 4'b0001, 16'h0000, 0, 0};
    tbl[1]  = '{4'b1101, pat[2],     32, 4'b0011, 16'h0000, 0, 0};
    tbl[2]  = '{4'b1011, pat[3],     32, 4'b0111, 16'h0000, 0, 0};
    tbl[3]  = '{4'b0111, pat[4],     32, 4'b0000, 16'h4321, 1, 0};
    tbl[4]  = '{4'b1110, pat[1],     10, 4'b0000, 16'h4321, 0, 0};
    tbl[5]  = '{4'b1101, pat[2],     32, 4'b0010, 16'h4321, 0, 0};
    tbl[6]  = '{4'b1011, 7'b1111111, 32, 4'b0010, 16'h4321, 0, 1};
    tbl[7]  = '{4'b1101, pat[2],     10, 4'b0010, 16'h4321, 0, 0};
    tbl[8]  = '{4'b1100, pat[2],     32, 4'b0010, 16'h4321, 0, 1};
    tbl[9]  = '{4'b1111, 7'b1111111,  5, 4'b0010, 16'h4321, 0, 0};
    tbl[10] = '{4'b1100, pat[5],     32, 4'b0010, 16'h4321, 0, 0};
    tbl[11] = '{4'b1011, pat[10],    32, 4'b0110, 16'h4321, 0, 0};
    tbl[12] = '{4'b1011, pat[15],    32, 4'b0110, 16'h4321, 0, 0};
    tbl[13] = '{4'b1110, pat[0],     32, 4'b0111, 16'h4321, 0, 0};
    tbl[14] = '{4'b1101, pat[0],     32, 4'b0111, 16'h4321, 0, 0};
    tbl[15] = '{4'b0111, pat[0],     32, 4'b0000, 16'h0F00, 1, 0};

    n_valid = 0;
    n_err   = 0;
    cyc('1, '1, 1'b1);
    cyc('1, '1, 1'b1);
    chk("reset_value", 32'(value), 32'h0);
    chk("reset_mask", 32'(digit_mask), 32'h0);
    chk("reset_pulses", {value_valid, decode_err}, 32'h0);

    n_valid = 0;
    n_err   = 0;
    dwell('1, '1, 100);
    chk("idle_pulses", 32'(n_valid + n_err), 32'h0);
    chk("idle_mask", 32'(digit_mask), 32'h0);

    for (int i = 0; i < 16; i++) begin
      n_valid = 0;
      n_err   = 0;
      dwell(tbl[i].an, tbl[i].seg, tbl[i].cyc);
      chk($sformatf("row%0d_mask", i), 32'(digit_mask), 32'(tbl[i].mask));
      chk($sformatf("row%0d_value", i), 32'(value), 32'(tbl[i].value));
      chk($sformatf("row%0d_valid", i), 32'(n_valid), 32'(tbl[i].nv));
      chk($sformatf("row%0d_err", i), 32'(n_err), 32'(tbl[i].ne));
    end

    dwell(4'b1110, pat[5], 32);
    dwell(4'b1101, pat[6], 32);
    dwell(4'b1011, pat[7], 32);
    chk("pre_rst_mask", 32'(digit_mask), 32'h7);
    cyc('1, '1, 1'b1);
    cyc('1, '1, 1'b1);
    chk("rst_mask", 32'(digit_mask), 32'h0);
    chk("rst_value", 32'(value), 32'h0);
    n_valid = 0;
    dwell(4'b1110, pat[8], 32);
    dwell(4'b1101, pat[9], 32);
    dwell(4'b1011, pat[10], 32);
    dwell(4'b0111, pat[11], 32);
    chk("fresh_value", 32'(value), 32'hBA98);
    chk("fresh_valid", 32'(n_valid), 32'h1);

    dwell('1, '1, 5);
    dwell(4'b1110, pat[3], 16);
    chk("lat_early", 32'(digit_mask), 32'h0);
    dwell(4'b1110, pat[3], 1);
    chk("lat_edge", 32'(digit_mask), 32'h1);

    repeat (150) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)
        ra = '1;
      else if (sel == 1)
        ra = ($urandom_range(0, 3) == 0) ? 4'b0000
           : ~(4'b0011 << $urandom_range(0, 2));
      else
        ra = ~(4'b0001 << $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)
        rs = 7'($urandom);
      else
        rs = pat[$urandom_range(0, 15)];
      if ($urandom_range(0, 49) == 0) cyc(ra, rs, 1'b1);
      dwell(ra, rs, int'($urandom_range(1, 40)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
